// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier driver: control-FSM state codes,
// driver state enum and the step count of the 8-bit multiply sequence.
package mult_pkg;

  localparam logic [2:0] CTL_IDLE  = 3'b000;
  localparam logic [2:0] CTL_LOAD  = 3'b001;
  localparam logic [2:0] CTL_CALC  = 3'b010;
  localparam logic [2:0] CTL_SHIFT = 3'b011;
  localparam logic [2:0] CTL_DONE  = 3'b100;
  localparam logic [2:0] CTL_ERR   = 3'b101;

  localparam int STEP_COUNT = 4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_STEP      = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESP      = 3'd4
  } drv_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] value
);

  always_ff @(posedge clk) begin
    if (clear) begin
      value <= '0;
    end else if (inc && (value != {W{1'b1}})) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/mult_driver.sv
// Request/response driver for a sequential 8-bit multiplier control unit.
// Optional statistics counters are enabled with MULT_DRIVER_STATS_EN.
module mult_driver
  import mult_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4,
  parameter int OPW            = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [OPW-1:0]   req_a,
  input  logic [OPW-1:0]   req_b,
  output logic             req_ready,
  output logic             start,
  output logic [1:0]       count,
  output logic [OPW-1:0]   dataa,
  output logic [OPW-1:0]   datab,
  input  logic             done,
  input  logic [2:0]       state_in,
  input  logic [2*OPW-1:0] product,
  output logic             res_valid,
  output logic [2*OPW-1:0] res_product,
  output logic             res_err,
  input  logic             res_ready
`ifdef MULT_DRIVER_STATS_EN
  ,
  output logic [15:0]      op_count,
  output logic [7:0]       err_count
`endif
);

  drv_state_t       state_q, state_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic [1:0]       count_d;
  logic [OPW-1:0]   dataa_d, datab_d;
  logic [2*OPW-1:0] res_product_d;
  logic             res_err_d;
  logic             ctl_err;

  assign ctl_err = (state_in == CTL_ERR);

  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    count_d       = count;
    dataa_d       = dataa;
    datab_d       = datab;
    res_product_d = res_product;
    res_err_d     = res_err;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          dataa_d = req_a;
          datab_d = req_b;
          count_d = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (ctl_err) begin
          res_product_d = '0;
          res_err_d     = 1'b1;
          count_d       = '0;
          state_d       = S_RESP;
        end else begin
          count_d = '0;
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        if (ctl_err) begin
          res_product_d = '0;
          res_err_d     = 1'b1;
          count_d       = '0;
          state_d       = S_RESP;
        end else if (count == 2'(STEP_COUNT - 1)) begin
          wcnt_d  = '0;
          state_d = S_WAIT_DONE;
        end else begin
          count_d = count + 2'd1;
        end
      end
      S_WAIT_DONE: begin
        // done wins over a simultaneous control error or timeout
        if (done) begin
          res_product_d = product;
          res_err_d     = 1'b0;
          state_d       = S_RESP;
        end else if (ctl_err || (wcnt_q == 4'(TIMEOUT_CYCLES - 1))) begin
          res_product_d = '0;
          res_err_d     = 1'b1;
          count_d       = '0;
          state_d       = S_RESP;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      S_RESP: begin
        if (res_ready) begin
          count_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      count       <= '0;
      dataa       <= '0;
      datab       <= '0;
      res_product <= '0;
      res_err     <= 1'b0;
      start       <= 1'b0;
      req_ready   <= 1'b1;
      res_valid   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      count       <= count_d;
      dataa       <= dataa_d;
      datab       <= datab_d;
      res_product <= res_product_d;
      res_err     <= res_err_d;
      start       <= (state_d == S_START);
      req_ready   <= (state_d == S_IDLE);
      res_valid   <= (state_d == S_RESP);
    end
  end

`ifdef MULT_DRIVER_STATS_EN
  logic xfer;
  assign xfer = (state_q == S_RESP) && res_ready;

  sat_counter #(.W(16)) u_op_count (
    .clk   (clk),
    .clear (reset),
    .inc   (xfer && !res_err),
    .value (op_count)
  );

  sat_counter #(.W(8)) u_err_count (
    .clk   (clk),
    .clear (reset),
    .inc   (xfer && res_err),
    .value (err_count)
  );
`endif

endmodule

// File: doc/mult_driver.md
MULT_DRIVER -- requirements
Module: mult_driver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4: max cycles spent in WAIT_DONE before an error is declared; legal range 1..15.
REQ-002 SHALL have parameter OPW, default 8: operand width; only value 8 is supported (4-step count sequence).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  operand pair offered.
REQ-006 req_a, req_b  input  8 each  operands.
REQ-007 req_ready  output  1  driver accepts a pair this cycle.
REQ-008 start  output  1  start pulse to the multiplier control.
REQ-009 count  output  2  step index to the multiplier control.
REQ-010 dataa, datab  output  8 each  latched operands to the datapath.
REQ-011 done  input  1  done flag from the multiplier control.
REQ-012 state_in  input  3  state_out of the multiplier control; 3'b101 = ERR.
REQ-013 product  input  16  datapath result.
REQ-014 res_valid  output  1  result available.
REQ-015 res_product  output  16  captured product.
REQ-016 res_err  output  1  result invalid (error/timeout); qualifies res_valid.
REQ-017 res_ready  input  1  consumer accepts the result.

Function
REQ-018 SHALL implement FSM states IDLE, START, STEP, WAIT_DONE, RESP.
REQ-019 IDLE: req_ready=1; on req_valid SHALL latch req_a/req_b into dataa/datab and go to START.
REQ-020 START: start=1, count=0 for exactly one cycle, then go to STEP with count=0.
REQ-021 STEP: start=0; count SHALL be 0,1,2,3 on four consecutive cycles, then go to WAIT_DONE.
REQ-022 WAIT_DONE: start=0, count=3; on done=1 SHALL capture product into res_product, res_err=0, and go to RESP.
REQ-023 In START, STEP or WAIT_DONE, if state_in==3'b101 SHALL go to RESP with res_err=1 and res_product=0 on the next cycle.
REQ-024 If WAIT_DONE lasts TIMEOUT_CYCLES cycles without done, SHALL go to RESP with res_err=1 and res_product=0.
REQ-025 If done and the error condition occur in the same cycle, done SHALL take priority.
REQ-026 RESP: res_valid=1, with res_product/res_err held stable, until res_ready=1; then go to IDLE. res_valid=1 with res_ready=1 in the same cycle SHALL complete the transfer.
REQ-027 req_ready SHALL be 0 in every state except IDLE; dataa/datab SHALL be stable from START through RESP.
REQ-028 Nominal latency from acceptance to res_valid SHALL be 7 cycles (1 START + 4 STEP + 1 WAIT_DONE with done + 1 registered RESP).
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 When reset=1 at a clock edge, SHALL go to IDLE, abort any operation with no result produced, and force start=0, count=0, dataa=datab=0, res_valid=0, res_err=0, res_product=0, req_ready=1 from the next cycle onward.

Configuration
REQ-031 With MULT_DRIVER_STATS_EN defined, SHALL add output ports op_count[15:0] (completed results with res_err=0) and err_count[7:0] (results with res_err=1), both saturating and cleared by reset, each incremented on the RESP handshake cycle.
REQ-032 Without MULT_DRIVER_STATS_EN, these ports and counters SHALL be absent.

Structure
REQ-033 Package mult_pkg SHALL hold the control-FSM state encodings (IDLE..ERR, 3'b000..3'b101), the driver state enum, and the STEP_COUNT=4 constant.
REQ-034 Sub-module sat_counter (parameterised width, inc, clear) SHALL implement both statistics counters.

Verification
REQ-035 req_a=8'd15, req_b=8'd13, done asserted in WAIT_DONE, product=16'd195 -> start high 1 cycle, count 0,0,1,2,3, res_valid=1 with res_product=195 and res_err=0, 7 cycles after acceptance.
REQ-036 done never asserted, TIMEOUT_CYCLES=4 -> res_valid=1, res_err=1, res_product=0 after 4 WAIT_DONE cycles.
REQ-037 state_in=3'b101 during STEP (count=1) -> RESP next cycle with res_err=1; next request pulses start and completes normally.
REQ-038 res_ready held 0 for 5 cycles -> res_valid and res_product held stable, req_ready=0 throughout; transfer completes on the cycle res_ready=1.
REQ-039 reset=1 asserted during STEP -> next cycle IDLE, start=0, res_valid=0, req_ready=1; no result emitted.
REQ-040 With MULT_DRIVER_STATS_EN: run 3 good operations and 1 timeout -> op_count=3, err_count=1.
